// File: rtl/ldpc_pkg.sv
// ============================================================================
// Module   : ldpc_pkg
// Brief    : Shared types and widths for the LDPC iteration controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int R_DEF      = 8;
  localparam int C_DEF      = 4;
  localparam int D_DEF      = 8;

  localparam int ITER_W = 8;
  localparam int LAT_W  = 4;

  localparam int NBITS = R_DEF * D_DEF;
  localparam int MTX_W = C_DEF * R_DEF * DATA_W_DEF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    STEP = 3'd2,
    WAIT = 3'd3,
    HOLD = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ldpc_frame_buf.sv
// ============================================================================
// Module   : ldpc_frame_buf
// Brief    : Load-enabled capture of channel bits and shift matrix.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldpc_frame_buf
  import ldpc_pkg::*;
#(
  parameter int NB = NBITS,
  parameter int MW = MTX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [NB-1:0] in_sig,
  input  logic [MW-1:0] in_mtx,
  output logic [NB-1:0] l,
  output logic [MW-1:0] mtx
);

  always_ff @(posedge clk) begin
    if (rst) begin
      l   <= '0;
      mtx <= '0;
    end else if (load) begin
      l   <= in_sig;
      mtx <= in_mtx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ldpc_iter_ctrl.sv
// ============================================================================
// Module   : ldpc_iter_ctrl
// Brief    : Frame capture and iteration sequencing for the layered LDPC
//            datapath; optional frame statistics under LDPC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int data_w   = DATA_W_DEF,
  parameter int R        = R_DEF,
  parameter int C        = C_DEF,
  parameter int D        = D_DEF,
  parameter int MAX_ITER = 32,
  parameter int ITER_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [R*D-1:0]        in_sig,
  input  logic [C*R*data_w-1:0] in_mtx,
  output logic [R*D-1:0]        l,
  output logic [C*R*data_w-1:0] mtx,
  output logic                  dp_init,
  output logic                  dp_step,
  input  logic [R*D-1:0]        dec,
  input  logic                  check,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [R*D-1:0]        res,
  output logic                  err,
  output logic [ITER_W-1:0]     iters
`ifdef LDPC_STATS_EN
  ,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_err
`endif
);

  localparam int NB = R * D;
  localparam int MW = C * R * data_w;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_done;
  logic [ITER_W-1:0]  r_iter;
  logic [LAT_W-1:0]   r_lat;
  logic [NB-1:0]      r_res;
  logic               r_err;
  logic [ITER_W-1:0]  r_iters;

  ldpc_frame_buf #(
    .NB (NB),
    .MW (MW)
  ) u_frame_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept),
    .in_sig (in_sig),
    .in_mtx (in_mtx),
    .l      (l),
    .mtx    (mtx)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs depend on state only, so pulses are clean single cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    in_ready    = 1'b0;
    dp_init     = 1'b0;
    dp_step     = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = INIT;
        end
      end
      INIT: begin
        dp_init     = 1'b1;
        w_state_nxt = STEP;
      end
      STEP: begin
        dp_step     = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_lat == '0) begin
          if (!check || (r_iter == ITER_W'(MAX_ITER))) begin
            w_done      = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_state_nxt = STEP;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter  <= '0;
      r_lat   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_iters <= '0;
    end else begin
      if (w_accept) r_iter <= '0;
      if (r_state == STEP) begin
        r_iter <= r_iter + 1'b1;
        r_lat  <= LAT_W'(ITER_LAT - 1);
      end else if ((r_state == WAIT) && (r_lat != '0)) begin
        r_lat <= r_lat - 1'b1;
      end
      // check still high here can only mean the budget ran out
      if (w_done) begin
        r_res   <= dec;
        r_err   <= check;
        r_iters <= r_iter;
      end
    end
  end

  assign res   = r_res;
  assign err   = r_err;
  assign iters = r_iters;

`ifdef LDPC_STATS_EN
  logic [15:0] r_frames_ok;
  logic [15:0] r_frames_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frames_ok  <= '0;
      r_frames_err <= '0;
    end else if (w_done) begin
      if (check) begin
        if (r_frames_err != 16'hFFFF) r_frames_err <= r_frames_err + 1'b1;
      end else begin
        if (r_frames_ok != 16'hFFFF) r_frames_ok <= r_frames_ok + 1'b1;
      end
    end
  end

  assign frames_ok  = r_frames_ok;
  assign frames_err = r_frames_err;
`endif

endmodule

`default_nettype wire
